uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver and the receive-side counterpart of the team's uart_tx.
- Synchronises the asynchronous serial input and detects the start bit.
- Samples each bit at mid-point using a 16x oversample tick, then presents each received byte with a one-cycle valid strobe and a framing-error flag.
- Self-contained: generates its own oversample tick and does not use baud_gen.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line bit rate.
- OVERSAMPLE, 16: ticks per bit. Fixed at 16; other values are unsupported.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  last received byte; LSB is received first.
- rx_valid  output  1  one-cycle pulse when rx_data and frame_err update.
- rx_busy  output  1  high whenever state != IDLE.
- frame_err  output  1  stop bit of the last byte sampled low; valid with rx_valid, held until the next byte.
- parity_err  output  1  parity mismatch on the last byte. Always 0 when the optional feature is compiled out.

Behaviour:
- Reset (synchronous, one cycle):
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0.
  - Synchroniser flops=1, state=IDLE, all counters=0.
  - Reset mid-frame aborts the frame with no rx_valid.
- Input synchroniser: two flops. rxs denotes the second stage. The first bit decision is therefore at least 2 cycles after an rx edge.
- Oversample tick:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation; DIV must be >= 1.
  - Free-running counter 0..DIV-1; tick is a one-cycle pulse when the counter equals DIV-1.
  - The counter never stops or resyncs.
- Counters: s_cnt (4-bit) counts ticks within a bit; b_cnt (3-bit) counts data bits.
- IDLE:
  - On rxs==0 (any cycle), go to START with s_cnt=0.
- START:
  - On tick, s_cnt++.
  - At a tick with s_cnt==7 (mid start bit):
    - rxs==0: go to DATA with s_cnt=0, b_cnt=0.
    - rxs==1: glitch; return to IDLE with no outputs changed.
- DATA:
  - On tick with s_cnt==15: sample rxs into the shift register (shift right; new bit enters the MSB) and set s_cnt=0.
  - After the 8th sample (b_cnt==7), go to STOP (or PARITY if enabled). Otherwise b_cnt++.
- STOP:
  - On tick with s_cnt==15, sample rxs.
  - In the next cycle: rx_valid=1, rx_data=shift register, frame_err=!sample.
  - If sample==1, go to IDLE. If sample==0, go to BREAK.
- BREAK:
  - Wait until rxs==1, then go to IDLE.
  - Prevents a held-low line (break) from retriggering a frame.
  - rx_busy stays high.
- Latency and pulse behaviour:
  - rx_valid occurs one clock after the mid-stop-bit tick, roughly 9.5 bit-times after the start edge.
  - rx_valid never lasts more than one cycle.
  - There is no backpressure: an unread byte is overwritten by the next frame.
- A new start bit is accepted in the same cycle that IDLE is re-entered, so back-to-back frames need no idle gap.
- Sampling at s_cnt==15 after the mid-start alignment places every later sample at bit centre, ±1 tick.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at a tick with s_cnt==15.
  - Parity is even; parity_err = sampled bit XOR (XOR of the 8 data bits).
  - parity_err updates together with rx_valid; frame length is 11 bits.
- Undefined:
  - No PARITY state; 10-bit frame.
  - parity_err is tied to 0.

Test Plan (bench: CLK_FREQ=1600000, BAUD=100000, so DIV=1 and 16 clk per bit):
- Frame 0xA5 with stop=1 -> exactly one rx_valid pulse; rx_data=0xA5; frame_err=0; rx_busy falls one cycle later.
- Low glitch of 4 clk on an idle line -> returns to IDLE; no rx_valid; rx_data unchanged.
- Frame 0x3C with stop=0, line held low for 40 clk, then high -> rx_valid with rx_data=0x3C and frame_err=1; rx_busy stays high until rxs returns high.
- Back-to-back frames 0x00, 0xFF with zero idle gap -> two rx_valid pulses 160 clk apart carrying 0x00 then 0xFF.
- Reset asserted for 1 cycle in the middle of data bit 4 of a frame, then a clean frame 0x5A -> no rx_valid from the aborted frame; next frame gives rx_data=0x5A.
- With UART_RX_PARITY_EN defined: 0x07 sent with parity bit 1 -> parity_err=0; 0x07 sent with parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 16x oversample tick, two-flop input synchroniser and break handling.
// Define UART_RX_PARITY_EN to receive an even parity bit between the data and stop bits.
module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             sync_q;
    logic             rxs;
    logic [3:0]       s_cnt;
    logic [2:0]       b_cnt;
    logic [7:0]       shreg;
    logic             stop_done;
    logic             stop_ok;
`ifdef UART_RX_PARITY_EN
    logic             par_bit;
    logic             par_err_q;
`endif

    // Free-running divider; never resynchronised to the line.
    assign tick = (div_cnt == DIV_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            sync_q <= rx;
            rxs    <= sync_q;
        end
    end

    assign rx_busy = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            s_cnt     <= '0;
            b_cnt     <= '0;
            shreg     <= '0;
            stop_done <= 1'b0;
            stop_ok   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state <= S_START;
                        s_cnt <= '0;
                    end
                end

                // Half a bit in: confirm the start bit or reject it as a glitch.
                S_START: begin
                    if (tick) begin
                        if (s_cnt == 4'd7) begin
                            if (!rxs) begin
                                state <= S_DATA;
                                s_cnt <= '0;
                                b_cnt <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            shreg <= {rxs, shreg[7:1]};
                            s_cnt <= '0;
                            if (b_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= S_PARITY;
`else
                                state <= S_STOP;
`endif
                            end else begin
                                b_cnt <= b_cnt + 3'd1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick) begin
                        if (s_cnt == 4'd15) begin
                            par_bit <= rxs;
                            s_cnt   <= '0;
                            state   <= S_STOP;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
`endif

                // Outputs update one clock after the stop sample; the state leaves a cycle later.
                S_STOP: begin
                    if (stop_done) begin
                        stop_done <= 1'b0;
                        state     <= stop_ok ? S_IDLE : S_BREAK;
                    end else if (tick) begin
                        if (s_cnt == 4'd15) begin
                            rx_valid  <= 1'b1;
                            rx_data   <= shreg;
                            frame_err <= !rxs;
                            stop_ok   <= rxs;
                            stop_done <= 1'b1;
                            s_cnt     <= '0;
`ifdef UART_RX_PARITY_EN
                            par_err_q <= par_bit ^ (^shreg);
`endif
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end

                // Hold off until the line idles so a break cannot start a new frame.
                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
